// File: rtl/l3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l3_pkg : opcodes, control-FSM state codes and instruction fields     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package l3_pkg;
  localparam logic [2:0] c_op_load = 3'b000;
  localparam logic [2:0] c_op_mv   = 3'b001;
  localparam logic [2:0] c_op_sub  = 3'b010;
  localparam logic [2:0] c_op_add  = 3'b011;
  localparam logic [2:0] c_op_disp = 3'b100;
  localparam logic [2:0] c_op_rsvd = 3'b101;
  localparam logic [2:0] c_op_subi = 3'b110;
  localparam logic [2:0] c_op_addi = 3'b111;

  localparam logic [3:0] c_fsm_idle = 4'b0000;
  localparam logic [3:0] c_fsm_done = 4'b1000;

  localparam int c_iw      = 10;
  localparam int c_op_msb  = 9;
  localparam int c_op_lsb  = 7;
  localparam int c_ax_msb  = 6;
  localparam int c_ax_lsb  = 5;
  localparam int c_ay_msb  = 4;
  localparam int c_ay_lsb  = 3;
  localparam int c_imm_msb = 2;
  localparam int c_imm_lsb = 0;
endpackage
`default_nettype wire

// File: rtl/l3_prog_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l3_prog_mem : DEPTH x DW program RAM, synchronous read, one writer   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module l3_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // No reset: program contents must survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/l3_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l3_sequencer : instruction fetch/issue stage feeding the l3 control  |
// |                FSM through an execute/DONE/IDLE handshake            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module l3_sequencer
  import l3_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [9:0]    prog_data,
  input  logic [3:0]    fsm_state,
  output logic          execute,
  output logic [2:0]    operation,
  output logic [1:0]    addr_x,
  output logic [1:0]    addr_y,
  output logic [2:0]    imm,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          error
);
  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_timeout = c_tw'(TIMEOUT);
  localparam logic [AW-1:0]   c_pc_last = AW'(DEPTH - 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_fetch   = 3'd1;
  localparam logic [2:0] c_st_load_ir = 3'd2;
  localparam logic [2:0] c_st_issue   = 3'd3;
  localparam logic [2:0] c_st_rel     = 3'd4;
  localparam logic [2:0] c_st_halt    = 3'd5;
  localparam logic [2:0] c_st_err     = 3'd6;

  logic [2:0]      r_state;
  logic [AW-1:0]   r_pc;
  logic [c_iw-1:0] r_ir;
  logic [c_tw-1:0] r_timer;
  logic [c_iw-1:0] w_rdata;
  logic            w_busy;
  logic            w_mem_we;

  assign w_busy = (r_state == c_st_fetch) || (r_state == c_st_load_ir) ||
                  (r_state == c_st_issue) || (r_state == c_st_rel);
  assign w_mem_we = prog_we & ~w_busy;

  // The RAM reads pc every cycle; the word captured at the end of FETCH
  // is what LOAD_IR latches.
  l3_prog_mem #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (c_iw)
  ) u_prog_mem (
    .clk  (clk),
    .we   (w_mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(r_pc),
    .rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_pc    <= '0;
      r_ir    <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) r_state <= c_st_fetch;
        end
        c_st_fetch: begin
          r_state <= c_st_load_ir;
        end
        c_st_load_ir: begin
          r_ir    <= w_rdata;
          r_timer <= '0;
          r_state <= (w_rdata[c_op_msb:c_op_lsb] == c_op_rsvd) ? c_st_halt : c_st_issue;
        end
        c_st_issue: begin
          if (r_timer != '1) r_timer <= r_timer + 1'b1;
          // DONE wins over a timeout landing on the same cycle.
          if (fsm_state == c_fsm_done) begin
            r_state <= c_st_rel;
          end else if (r_timer == c_timeout) begin
            r_state <= c_st_err;
          end
        end
        c_st_rel: begin
          if (fsm_state == c_fsm_idle) begin
            if (r_pc == c_pc_last) begin
              r_state <= c_st_halt;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= c_st_fetch;
            end
          end
        end
        c_st_halt, c_st_err: begin
          if (start) begin
            r_pc    <= '0;
            r_state <= c_st_fetch;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign execute   = (r_state == c_st_issue);
  assign operation = r_ir[c_op_msb:c_op_lsb];
  assign addr_x    = r_ir[c_ax_msb:c_ax_lsb];
  assign addr_y    = r_ir[c_ay_msb:c_ay_lsb];
  assign imm       = r_ir[c_imm_msb:c_imm_lsb];
  assign pc        = r_pc;
  assign busy      = w_busy;
  assign halted    = (r_state == c_st_halt);
  assign error     = (r_state == c_st_err);
endmodule
`default_nettype wire

// File: tb/tb_l3_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l3_sequencer : bench with behavioural sequencer model and a       |
// |                   control-FSM responder                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_l3_sequencer;
  import l3_pkg::*;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [9:0]    prog_data = '0;
  logic [3:0]    fsm_state = '0;
  logic          execute;
  logic [2:0]    operation;
  logic [1:0]    addr_x;
  logic [1:0]    addr_y;
  logic [2:0]    imm;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          error;

  always #5 clk = ~clk;

  l3_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .fsm_state(fsm_state),
    .execute(execute), .operation(operation), .addr_x(addr_x), .addr_y(addr_y),
    .imm(imm), .pc(pc), .busy(busy), .halted(halted), .error(error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: phases follow the instruction lifecycle; the program
  // is a plain array read at load time.
  typedef enum int {M_IDLE, M_FETCH, M_LOAD, M_ISSUE, M_REL, M_HALT, M_ERR} mph_t;
  mph_t       ph = M_IDLE;
  int         m_pc = 0;
  int         m_wait = 0;
  logic [9:0] m_ir = '0;
  logic [9:0] m_prog [DEPTH];
  logic [2:0] m_log [$];
  bit         m_was_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = M_IDLE; m_pc = 0; m_ir = '0; m_wait = 0;
    end else begin
      m_was_busy = ph inside {M_FETCH, M_LOAD, M_ISSUE, M_REL};
      case (ph)
        M_IDLE:  if (start) ph = M_FETCH;
        M_FETCH: ph = M_LOAD;
        M_LOAD: begin
          m_ir = m_prog[m_pc];
          m_wait = 0;
          if (m_ir[9:7] == c_op_rsvd) ph = M_HALT;
          else begin ph = M_ISSUE; m_log.push_back(m_ir[9:7]); end
        end
        M_ISSUE: begin
          m_wait++;
          if (fsm_state == 4'b1000) ph = M_REL;
          else if (m_wait == TIMEOUT + 1) ph = M_ERR;
        end
        M_REL: if (fsm_state == 4'b0000) begin
          if (m_pc == DEPTH - 1) ph = M_HALT;
          else begin m_pc++; ph = M_FETCH; end
        end
        default: if (start) begin m_pc = 0; ph = M_FETCH; end
      endcase
      if (prog_we && !m_was_busy) m_prog[prog_addr] = prog_data;
    end
  end

  function automatic logic [17:0] exp_vec();
    return {ph == M_ISSUE, m_ir, 4'(m_pc), ph inside {M_FETCH, M_LOAD, M_ISSUE, M_REL},
            ph == M_HALT, ph == M_ERR};
  endfunction

  logic [17:0] dut_vec;
  assign dut_vec = {execute, operation, addr_x, addr_y, imm, pc, busy, halted, error};

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: dut=%h model=%h", $time, dut_vec, exp_vec());
      end
    end
  end

  logic [2:0] dut_log [$];
  logic       exec_q = 1'b0;
  always @(negedge clk) begin
    if (execute === 1'b1 && exec_q !== 1'b1) dut_log.push_back(operation);
    exec_q = execute;
  end

  // Control-FSM responder: 0 = silent, 1 = DONE after resp_delay, 2 = random.
  int resp_mode = 1;
  int resp_delay = 4;
  int rcnt = 0, rdly = 1, rel_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (!reset_n || resp_mode == 0) begin
      fsm_state = 4'b0000; rcnt = 0;
    end else if (execute) begin
      if (fsm_state != 4'b1000) begin
        if (rcnt == 0) rdly = (resp_mode == 2) ? int'($urandom_range(1, 6)) : resp_delay;
        rcnt++;
        if (rcnt >= rdly) begin
          fsm_state = 4'b1000;
          rel_cnt = (resp_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        end else begin
          fsm_state = (resp_mode == 2) ? 4'($urandom_range(1, 7)) : 4'b0001;
        end
      end
    end else begin
      rcnt = 0;
      if (rel_cnt > 0) rel_cnt--;
      else fsm_state = 4'b0000;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [9:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stop(input string name, input int maxc);
    int n = 0;
    while (!(halted || error) && n < maxc) begin tick(); n++; end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL %s: no halt/error within %0d cycles", name, maxc);
    end
  endtask

  task automatic wait_exec(input string name, input int maxc);
    int n = 0;
    while (!execute && n < maxc) begin tick(); n++; end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL %s: execute never rose within %0d cycles", name, maxc);
    end
  endtask

  task automatic clear_logs();
    dut_log.delete();
    m_log.delete();
  endtask

  task automatic check_log(input string name, input logic [2:0] exp_q [$]);
    check({name, "_dut_count"}, dut_log.size(), exp_q.size());
    check({name, "_model_count"}, m_log.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < dut_log.size()) check({name, "_dut_op"}, dut_log[i], exp_q[i]);
      if (i < m_log.size()) check({name, "_model_op"}, m_log[i], exp_q[i]);
    end
  endtask

  function automatic logic [9:0] instr(input logic [2:0] op);
    logic [6:0] f;
    f = 7'($urandom);
    return {op, f};
  endfunction

  logic [2:0] ops [8];
  logic [2:0] exp_q [$];

  initial begin
    int n;
    ops = '{c_op_load, c_op_mv, c_op_sub, c_op_add, c_op_disp, c_op_rsvd, c_op_subi, c_op_addi};
    cmp_en = 1'b1;
    tick(3);
    check("reset_outputs", dut_vec, 18'h0);
    reset_n = 1'b1;
    tick();

    for (int a = 3; a < DEPTH; a++) write_mem(a, instr(c_op_add));
    write_mem(0, 10'b0110100000);
    write_mem(1, {c_op_sub, 2'b10, 2'b11, 3'b101});
    write_mem(2, {c_op_rsvd, 7'b0});

    // Basic program: ADD, SUB, then reserved opcode halts.
    resp_mode = 1; resp_delay = 4;
    clear_logs();
    pulse_start();
    wait_stop("basic", 200);
    check("basic_halted", halted, 1);
    check("basic_error", error, 0);
    check("basic_pc", pc, 2);
    exp_q = {3'b011, 3'b010};
    check_log("basic_log", exp_q);

    // Restart from HALT: pc clears, execute three clocks after start sampled.
    clear_logs();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_pc", pc, 0);
    check("restart_busy", busy, 1);
    n = 1;
    while (!execute && n < 10) begin tick(); n++; end
    check("restart_latency", n, 3);
    wait_stop("restart", 200);
    check_log("restart_log", exp_q);

    // Timeout: FSM never answers.
    resp_mode = 0;
    pulse_start();
    wait_exec("timeout_exec", 20);
    n = 0;
    while (!error && n < 40) begin tick(); n++; end
    check("timeout_cycles", n, TIMEOUT + 1);
    check("timeout_execute", execute, 0);
    check("timeout_pc", pc, 0);

    // Full memory: sixteen handshakes, halt at the last entry without wrap.
    resp_mode = 2;
    for (int a = 0; a < DEPTH; a++) write_mem(a, instr(c_op_add));
    clear_logs();
    pulse_start();
    wait_stop("full", 800);
    check("full_halted", halted, 1);
    check("full_pc", pc, DEPTH - 1);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(c_op_add);
    check_log("full_log", exp_q);
    tick(5);
    check("full_pc_hold", pc, DEPTH - 1);

    // Write while busy is dropped; write together with start in IDLE lands.
    write_mem(0, instr(c_op_add));
    write_mem(1, instr(c_op_sub));
    write_mem(2, instr(c_op_addi));
    write_mem(3, instr(c_op_rsvd));
    clear_logs();
    pulse_start();
    tick(3);
    check("wr_busy_state", busy, 1);
    write_mem(1, instr(c_op_mv));
    wait_stop("wr_busy", 300);
    exp_q = {3'b011, 3'b010, 3'b111};
    check_log("wr_busy_log", exp_q);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
    clear_logs();
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = instr(c_op_mv); start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_stop("wr_idle", 300);
    exp_q = {3'b011, 3'b001, 3'b111};
    check_log("wr_idle_log", exp_q);

    // Asynchronous reset during ISSUE, then rerun from retained memory.
    pulse_start();
    wait_exec("rst_mid_exec", 20);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_execute", execute, 0);
    check("rst_mid_pc", pc, 0);
    check("rst_mid_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick();
    clear_logs();
    pulse_start();
    wait_stop("rst_rerun", 300);
    check_log("rst_rerun_log", exp_q);

    // Randomised programs with write attempts throughout the run.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) write_mem(a, instr(ops[$urandom_range(0, 7)]));
      clear_logs();
      pulse_start();
      n = 0;
      while (!(halted || error) && n < 1500) begin
        if ($urandom_range(0, 3) == 0) begin
          prog_we = 1'b1; prog_addr = AW'($urandom); prog_data = 10'($urandom);
        end else begin
          prog_we = 1'b0;
        end
        tick();
        n++;
      end
      prog_we = 1'b0;
      if (n >= 1500) begin
        checks++; errors++;
        $display("FAIL random_run: no halt/error within 1500 cycles");
      end
      check("random_log_count", dut_log.size(), m_log.size());
      foreach (m_log[i]) if (i < dut_log.size()) check("random_log_op", dut_log[i], m_log[i]);
    end

    tick(2);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule
`default_nettype wire
